// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider for DIV/DIVU (quotient -> LO,
// remainder -> HI). One trial subtraction per cycle, WIDTH+1 cycle latency.
// Optional feature macro: SEQ_DIV_SIGNED_EN enables signed (DIV) support.
// When it is undefined, every operation runs as DIVU.
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;       // partial remainder
    logic [WIDTH-1:0] quo;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dsr;       // divisor magnitude
    logic [WIDTH-1:0] raw_dvd;   // unmodified dividend for the divide-by-zero result
    logic             neg_quo;   // operand signs differed
    logic             neg_rem;   // dividend was negative
    logic             zero_dsr;

    logic             last_step;
    logic [WIDTH:0]   trial;
    logic             load_neg_dvd, load_neg_dsr;
    logic [WIDTH-1:0] load_dvd, load_dsr;
    logic [WIDTH-1:0] fix_quo, fix_rem;

    assign last_step = (count == CW'(WIDTH - 1));

    // The trial difference's MSB set means the shifted remainder is below the divisor.
    assign trial = {rem, quo[WIDTH-1]} - {1'b0, dsr};

`ifdef SEQ_DIV_SIGNED_EN
    assign load_neg_dvd = signed_op & dividend[WIDTH-1];
    assign load_neg_dsr = signed_op & divisor[WIDTH-1];
    assign load_dvd     = load_neg_dvd ? -dividend : dividend;
    assign load_dsr     = load_neg_dsr ? -divisor  : divisor;
    assign fix_quo      = neg_quo ? -quo : quo;
    assign fix_rem      = neg_rem ? -rem : rem;
`else
    logic unused_signed_op;
    logic unused_neg;
    assign unused_signed_op = signed_op;
    assign unused_neg       = neg_quo | neg_rem;
    assign load_neg_dvd     = 1'b0;
    assign load_neg_dsr     = 1'b0;
    assign load_dvd         = dividend;
    assign load_dsr         = divisor;
    assign fix_quo          = quo;
    assign fix_rem          = rem;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // flop samples pre-edge values regardless of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: busy covers RUN and FIX; done is registered with results.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: operand capture, restoring steps, and result write-back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dsr         <= '0;
            raw_dvd     <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            zero_dsr    <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= '0;
                        rem      <= '0;
                        quo      <= load_dvd;
                        dsr      <= load_dsr;
                        raw_dvd  <= dividend;
                        neg_quo  <= load_neg_dvd ^ load_neg_dsr;
                        neg_rem  <= load_neg_dvd;
                        zero_dsr <= (divisor == '0);
                    end
                end
                RUN: begin
                    rem   <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    count <= count + CW'(1);
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= zero_dsr;
                    quotient    <= zero_dsr ? '1 : fix_quo;
                    remainder   <= zero_dsr ? raw_dvd : fix_rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Directed testbench for seq_div (WIDTH=32). Expected values for signed
// requests follow SEQ_DIV_SIGNED_EN, matching the build of the DUT.
module tb_seq_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks   = 0;
    int failures = 0;

    seq_div #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one request, optionally pulse a second start (9/3) while busy,
    // then wait (bounded) for done and check results, latency and busy.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic exp_z, input int inject_at);
        int lat;
        int busy_err;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        busy_err = (busy && !done) ? 0 : 1;
        while (!done && lat < 100) begin
            if (lat == inject_at) begin
                start     = 1'b1;
                dividend  = 32'd9;
                divisor   = 32'd3;
                signed_op = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (!done && !busy) busy_err++;
            if (done && busy)   busy_err++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_busy"}, 64'(busy_err), 64'd0);
        check({tag, "_q"}, 64'(quotient), 64'(exp_q));
        check({tag, "_r"}, 64'(remainder), 64'(exp_r));
        check({tag, "_dz"}, 64'(div_by_zero), 64'(exp_z));
    endtask

    initial begin
        int done_cnt;
        rst_n     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_q", 64'(quotient), 64'd0);
        rst_n = 1'b1;

        // Unsigned basic case.
        run_op("u_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, -1);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("q_held", 64'(quotient), 64'd14);

`ifdef SEQ_DIV_SIGNED_EN
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, -1);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, -1);
        run_op("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, -1);
`else
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, -1);
        run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0, -1);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, -1);
        run_op("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd0, 32'hFFFF_FF9C, 1'b0, -1);
`endif
        run_op("s_m7_as_u", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, -1);

        // Divide by zero in both modes, including a negative dividend.
        run_op("dz_u", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, -1);
        run_op("dz_s", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, -1);
        run_op("dz_s_neg", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, -1);

        // Start while busy is ignored; operand changes mid-run have no effect.
        run_op("hs_ignore", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 10);

        // Back-to-back: issue in the done cycle.
        check("b2b_in_done_cycle", 64'(done), 64'd1);
        run_op("hs_b2b", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, -1);

        // Reset mid-operation aborts without done.
        @(negedge clk);
        dividend  = 32'd1000;
        divisor   = 32'd9;
        signed_op = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("abort_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_dz", 64'(div_by_zero), 64'd0);
        check("abort_q", 64'(quotient), 64'd0);
        check("abort_r", 64'(remainder), 64'd0);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        run_op("after_abort", 32'd1000, 32'd9, 1'b0, 32'd111, 32'd1, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
